// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu - load/store unit between the execute-stage ALU and the data memory port.
//
// One memory transaction is in flight at a time. The ALU result is the
// effective address and register operand 2 is the store data. The unit handles
// byte, half and word sizing, byte enables, store lane replication, load
// sign/zero extension and illegal-size errors. It returns a single-cycle
// completion pulse carrying the extended load value and the destination tag.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned H/HU/SH (addr[0]=1) and W/SW (addr[1:0]!=0)
//               complete immediately with rsp_err=1 and make no memory access.
//   undefined : the offending low address bits are ignored. H uses the half
//               selected by addr[1] and W uses the word address.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready      request handshake from execute (ready only in IDLE)
//   req_we                     1 = store, 0 = load
//   req_funct3                 RISC-V size code (B/H/W/BU/HU)
//   req_addr, req_wdata        effective address, store data
//   req_rd                     destination register tag, echoed on rsp_rd
//   mem_req / mem_gnt          memory request strobe and grant
//   mem_we, mem_addr, mem_be   write flag, word-aligned address, byte enables
//   mem_wdata                  lane-replicated store data
//   mem_rvalid, mem_rdata      read data return
//   rsp_valid                  one-cycle completion pulse
//   rsp_data, rsp_rd, rsp_err  extended load data (0 for stores/errors), tag, fault
//   busy                       FSM is not in IDLE
//
// D_WIDTH is a parameter for port sizing only; the lane logic assumes 32.
// -----------------------------------------------------------------------------
module lsu #(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [D_WIDTH-1:0] req_addr,
    input  logic [D_WIDTH-1:0] req_wdata,
    input  logic [4:0]         req_rd,

    output logic               mem_req,
    output logic               mem_we,
    output logic [D_WIDTH-1:0] mem_addr,
    output logic [3:0]         mem_be,
    output logic [D_WIDTH-1:0] mem_wdata,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [D_WIDTH-1:0] mem_rdata,

    output logic               rsp_valid,
    output logic [D_WIDTH-1:0] rsp_data,
    output logic [4:0]         rsp_rd,
    output logic               rsp_err,
    output logic               busy
);

    // RISC-V load/store size codes.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic                 we_q, we_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [D_WIDTH-1:0]   addr_q, addr_d;
    logic [D_WIDTH-1:0]   wdata_q, wdata_d;
    logic [4:0]           rd_q, rd_d;
    logic [D_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [4:0]           rsp_rd_q, rsp_rd_d;
    logic                 rsp_err_q, rsp_err_d;

    // -------------------------------------------------------------------------
    // Request classification (evaluated on the incoming request in IDLE)
    // -------------------------------------------------------------------------
    // Loads accept B/H/W/BU/HU. Stores accept B/H/W only, because an
    // "unsigned store" has no meaning.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        case (f3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = we;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

    logic req_illegal;
    logic req_trap;

    assign req_illegal = f3_illegal(req_we, req_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
    // funct3[1:0] encodes the size for both signed and unsigned loads.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = a[0];
            2'b10:   mis = (a != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    assign req_trap = misaligned(req_funct3, req_addr[1:0]);
`else
    assign req_trap = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Memory-side datapath, built from the registered request
    // -------------------------------------------------------------------------
    logic [3:0]         be_raw;
    logic [D_WIDTH-1:0] wdata_rep;

    always_comb begin
        // NOTE: every always_comb output gets a default before the case, so no
        // path can leave it unassigned and infer a latch.
        be_raw    = 4'b1111;
        wdata_rep = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                be_raw    = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_raw    = 4'b0011 << {addr_q[1], 1'b0};
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                be_raw    = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Load lane select and extension
    // -------------------------------------------------------------------------
    logic [7:0]         byte_lane;
    logic [15:0]        half_lane;
    logic [D_WIDTH-1:0] load_ext;

    always_comb begin
        byte_lane = 8'h00;
        half_lane = 16'h0000;
        load_ext  = mem_rdata;

        case (addr_q[1:0])
            2'b00:   byte_lane = mem_rdata[7:0];
            2'b01:   byte_lane = mem_rdata[15:8];
            2'b10:   byte_lane = mem_rdata[23:16];
            default: byte_lane = mem_rdata[31:24];
        endcase
        // addr[0] is ignored for halves, so a misaligned H (untrapped build)
        // reads the half selected by addr[1].
        half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (funct3_q)
            F3_B:    load_ext = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   load_ext = {24'h000000, byte_lane};
            F3_H:    load_ext = {{16{half_lane[15]}}, half_lane};
            F3_HU:   load_ext = {16'h0000, half_lane};
            default: load_ext = mem_rdata;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM next-state and register updates
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        rsp_data_d = rsp_data_q;
        rsp_rd_d   = rsp_rd_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rd_d     = req_rd;
                    if (req_illegal || req_trap) begin
                        // Faulting access: complete without touching memory.
                        // The tag comes straight from the request because
                        // rd_q is only being loaded this cycle.
                        state_d    = S_DONE;
                        rsp_data_d = '0;
                        rsp_rd_d   = req_rd;
                        rsp_err_d  = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end

            S_REQ: begin
                if (mem_gnt) begin
                    if (we_q) begin
                        state_d    = S_DONE;
                        rsp_data_d = '0;
                        rsp_rd_d   = rd_q;
                        rsp_err_d  = 1'b0;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d    = S_DONE;
                    rsp_data_d = load_ext;
                    rsp_rd_d   = rd_q;
                    rsp_err_d  = 1'b0;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The request payload registers are reset too. The gated mem_* outputs
    // and the held rsp_* values then come out of reset as defined zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 5'd0;
            rsp_data_q <= '0;
            rsp_rd_q   <= 5'd0;
            rsp_err_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // flop samples its pre-edge value no matter how the statements are
            // ordered.
            state_q    <= state_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            rsp_data_q <= rsp_data_d;
            rsp_rd_q   <= rsp_rd_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    logic in_req;
    assign in_req = (state_q == S_REQ);

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);

    // The memory fields are qualified by REQ. They stay constant while the
    // grant is pending and read as zero otherwise. Because they derive from
    // the asynchronously reset state register, a reset drops mem_req at once.
    assign mem_req   = in_req;
    assign mem_we    = in_req & we_q;
    assign mem_addr  = in_req ? {addr_q[D_WIDTH-1:2], 2'b00} : '0;
    assign mem_be    = in_req ? be_raw : 4'b0000;
    assign mem_wdata = in_req ? wdata_rep : '0;

    assign rsp_valid = (state_q == S_DONE);
    assign rsp_data  = rsp_data_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu - self-checking bench for lsu.
//
// The stimulus issues directed accesses and plays the memory side with
// configurable grant and read-data delays. For each access it pushes the
// expected completion (data, tag, error, latency) into a scoreboard queue.
// An independent monitor pops the queue whenever rsp_valid is seen.
// Outputs are sampled on the falling edge and inputs change there too.
// -----------------------------------------------------------------------------
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;
    logic        busy;

    lsu #(.D_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_rd     (rsp_rd),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
        int          lat;
        int          acc;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   next_id = 0;

    // Expected values of the held response outputs, tracked by the bench.
    logic [31:0] last_data = '0;
    logic [4:0]  last_rd   = '0;
    logic        last_err  = 1'b0;

    // Monitor: each rsp_valid cycle consumes exactly one expected entry.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("rsp%0d_data", e.id), rsp_data, e.data);
                check($sformatf("rsp%0d_rd", e.id), 32'(rsp_rd), 32'(e.rd));
                check($sformatf("rsp%0d_err", e.id), 32'(rsp_err), 32'(e.err));
                check($sformatf("rsp%0d_latency", e.id), 32'(cyc - e.acc), 32'(e.lat));
                last_data = e.data;
                last_rd   = e.rd;
                last_err  = e.err;
            end
        end
    end

    // One access. Set exp_mem=0 for a faulting request that must not reach
    // memory; mem-side expectations are then ignored.
    task automatic access(
        input logic        we,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [4:0]  rd,
        input int          gnt_dly,
        input int          rv_dly,
        input logic [31:0] rdata,
        input logic        exp_mem,
        input logic [31:0] exp_addr,
        input logic [3:0]  exp_be,
        input logic [31:0] exp_wdata,
        input logic [31:0] exp_data,
        input logic        exp_err
    );
        exp_t e;
        int   id;
        id = next_id++;

        @(negedge clk);
        // The response outputs still hold the previous completion.
        check($sformatf("acc%0d_idle_ready", id), 32'({req_ready, busy}), 32'b10);
        check($sformatf("acc%0d_hold_data", id), rsp_data, last_data);
        check($sformatf("acc%0d_hold_rd_err", id), 32'({rsp_rd, rsp_err}), 32'({last_rd, last_err}));

        e.data = exp_data;
        e.rd   = rd;
        e.err  = exp_err;
        e.acc  = cyc;
        e.id   = id;
        if (!exp_mem)  e.lat = 1;
        else if (we)   e.lat = 2 + gnt_dly;
        else           e.lat = 3 + gnt_dly + rv_dly;
        sb.push_back(e);

        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;

        @(negedge clk);
        // Scramble the request bus so that the DUT must use its captured copy.
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b111;
        req_addr   = ~addr;
        req_wdata  = ~wdata;
        req_rd     = ~rd;

        if (!exp_mem) begin
            check($sformatf("acc%0d_no_mem_req", id), 32'(mem_req), 32'd0);
        end else begin
            for (int i = 0; i <= gnt_dly; i++) begin
                if (i > 0) @(negedge clk);
                check($sformatf("acc%0d_req_ctl_c%0d", id, i),
                      32'({mem_req, mem_we, mem_be, busy, req_ready}),
                      32'({1'b1, we, exp_be, 1'b1, 1'b0}));
                check($sformatf("acc%0d_req_addr_c%0d", id, i), mem_addr, exp_addr);
                if (we)
                    check($sformatf("acc%0d_req_wdata_c%0d", id, i), mem_wdata, exp_wdata);
                mem_gnt = (i == gnt_dly);
            end
            @(negedge clk);
            mem_gnt = 1'b0;
            if (!we) begin
                for (int i = 0; i <= rv_dly; i++) begin
                    if (i > 0) @(negedge clk);
                    check($sformatf("acc%0d_wait_c%0d", id, i),
                          32'({mem_req, busy, req_ready, rsp_valid}), 32'b0100);
                    mem_rvalid = (i == rv_dly);
                    mem_rdata  = (i == rv_dly) ? rdata : ~rdata;
                end
                @(negedge clk);
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h0;
            end
        end
    endtask

    // Start a load and abort it with reset, either in REQ or in WAIT.
    task automatic abort_load(input logic in_wait);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_8000;
        req_wdata  = 32'h0;
        req_rd     = 5'd30;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_req_phase", 32'(mem_req), 32'd1);
        if (in_wait) begin
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            check("abort_wait_phase", 32'({mem_req, busy}), 32'b01);
        end
        #2 rst_n = 1'b0;
        #1;
        check(in_wait ? "abort_wait_rst_now" : "abort_req_rst_now",
              32'({mem_req, busy, req_ready, rsp_valid}), 32'b0010);
        last_data = '0;
        last_rd   = '0;
        last_err  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // A late read return from the abandoned load must be dropped.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("abort_late_rvalid_ignored", 32'({busy, rsp_valid}), 32'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_rd     = 5'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        repeat (3) @(negedge clk);
        check("reset_ctl", 32'({req_ready, mem_req, mem_we, mem_be, rsp_valid, rsp_err, busy}),
              32'({1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0}));
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_wdata", mem_wdata, 32'h0);
        check("reset_rsp", rsp_data | 32'(rsp_rd), 32'h0);
        rst_n = 1'b1;

        // Stray grant/read-data in IDLE must not start anything.
        @(negedge clk);
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        check("stray_idle_ignored", 32'({busy, req_ready, rsp_valid}), 32'b010);

        //     we    f3      addr          wdata         rd    g  r  rdata         mem   exp_addr      be       exp_wdata     exp_data      err
        // SB to top byte lane
        access(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd5, 0, 0, 32'h0,         1'b1, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 32'h0,         1'b0);
        // SB to bottom byte lane
        access(1'b1, 3'b000, 32'h0000_1000, 32'h1234_5677, 5'd6, 0, 0, 32'h0,         1'b1, 32'h0000_1000, 4'b0001, 32'h7777_7777, 32'h0,         1'b0);
        // LB / LBU from lane 1
        access(1'b0, 3'b000, 32'h0000_2001, 32'h0,         5'd7, 0, 0, 32'h1234_8067, 1'b1, 32'h0000_2000, 4'b0010, 32'h0,         32'hFFFF_FF80, 1'b0);
        access(1'b0, 3'b100, 32'h0000_2001, 32'h0,         5'd8, 0, 0, 32'h1234_8067, 1'b1, 32'h0000_2000, 4'b0010, 32'h0,         32'h0000_0080, 1'b0);
        // LH / LHU from upper half
        access(1'b0, 3'b001, 32'h0000_2002, 32'h0,         5'd9, 0, 0, 32'h8000_1234, 1'b1, 32'h0000_2000, 4'b1100, 32'h0,         32'hFFFF_8000, 1'b0);
        access(1'b0, 3'b101, 32'h0000_2002, 32'h0,        5'd10, 0, 0, 32'h8000_1234, 1'b1, 32'h0000_2000, 4'b1100, 32'h0,         32'h0000_8000, 1'b0);
        // SH with grant wait states
        access(1'b1, 3'b001, 32'h0000_4002, 32'h1234_BEEF, 5'd11, 3, 0, 32'h0,        1'b1, 32'h0000_4000, 4'b1100, 32'hBEEF_BEEF, 32'h0,         1'b0);
        // LW with grant and read-data wait states
        access(1'b0, 3'b010, 32'h0000_5004, 32'h0,        5'd12, 3, 2, 32'hDEAD_BEEF, 1'b1, 32'h0000_5004, 4'b1111, 32'h0,         32'hDEAD_BEEF, 1'b0);
        // SW passes data through
        access(1'b1, 3'b010, 32'h0000_7000, 32'hCAFE_F00D, 5'd13, 0, 0, 32'h0,        1'b1, 32'h0000_7000, 4'b1111, 32'hCAFE_F00D, 32'h0,         1'b0);
        // Illegal size codes: no memory traffic, error after one cycle
        access(1'b0, 3'b011, 32'h0000_6000, 32'h0,        5'd14, 0, 0, 32'h0,         1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1);
        access(1'b1, 3'b100, 32'h0000_6000, 32'h55,       5'd15, 0, 0, 32'h0,         1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1);
        access(1'b0, 3'b110, 32'h0000_6004, 32'h0,        5'd16, 0, 0, 32'h0,         1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1);
        access(1'b1, 3'b111, 32'h0000_6008, 32'h0,        5'd17, 0, 0, 32'h0,         1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1);
        // Misaligned LW at 0x3002
`ifdef LSU_MISALIGN_TRAP_EN
        access(1'b0, 3'b010, 32'h0000_3002, 32'h0,        5'd18, 0, 0, 32'h0BAD_F00D, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1);
        access(1'b0, 3'b001, 32'h0000_3001, 32'h0,        5'd19, 0, 0, 32'h0BAD_F00D, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1);
`else
        access(1'b0, 3'b010, 32'h0000_3002, 32'h0,        5'd18, 0, 0, 32'h0BAD_F00D, 1'b1, 32'h0000_3000, 4'b1111, 32'h0,         32'h0BAD_F00D, 1'b0);
        access(1'b0, 3'b001, 32'h0000_3001, 32'h0,        5'd19, 0, 0, 32'h0BAD_F00D, 1'b1, 32'h0000_3000, 4'b0011, 32'h0,         32'hFFFF_F00D, 1'b0);
`endif

        // Reset while the load is outstanding, then a normal access afterwards.
        abort_load(1'b0);
        abort_load(1'b1);
        access(1'b0, 3'b000, 32'h0000_2003, 32'h0,        5'd20, 1, 1, 32'h7F12_3456, 1'b1, 32'h0000_2000, 4'b1000, 32'h0,         32'h0000_007F, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
